// File: rtl/matrix_slot_allocator_pkg.sv
// Shared types and constants for the matrix slot allocator.
// Error codes, FSM states and slot geometry defaults.
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 8
`endif

package matrix_slot_allocator_pkg;

  localparam int MAX_SLOTS      = 16;
  localparam int SLOT_WORDS_DEF = 32;

  typedef enum logic [1:0] {
    ALLOC_ERR_NONE      = 2'd0,
    ALLOC_ERR_NO_SPACE  = 2'd1,
    ALLOC_ERR_DIM_LIMIT = 2'd2
  } alloc_err_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DECIDE,
    S_RESP
  } alloc_state_e;

endpackage

// File: rtl/matrix_slot_allocator_table.sv
// Slot table: valid/reserved/dims/rank per slot, commit/abort/grant
// updates with same-dim rank aging, and the registered query port.
module matrix_slot_allocator_table
  import matrix_slot_allocator_pkg::*;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int SLOT_WORDS = SLOT_WORDS_DEF,
  parameter int ADDR_WIDTH = `BRAM_ADDR_WIDTH,
  localparam int IW        = $clog2(NUM_SLOTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          commit_i,
  input  logic [3:0]                    commit_slot_i,
  input  logic                          abort_i,
  input  logic [3:0]                    abort_slot_i,
  input  logic                          grant_i,
  input  logic                          grant_evict_i,
  input  logic [IW-1:0]                 grant_idx_i,
  input  logic [3:0]                    grant_m_i,
  input  logic [3:0]                    grant_n_i,
  input  logic [3:0]                    query_slot_i,
  output logic [NUM_SLOTS-1:0]          valid_o,
  output logic [NUM_SLOTS-1:0]          rsv_o,
  output logic [NUM_SLOTS-1:0][3:0]     m_o,
  output logic [NUM_SLOTS-1:0][3:0]     n_o,
  output logic [NUM_SLOTS-1:0][3:0]     rank_o,
  output logic                          upd_o,
  output logic                          query_valid_o,
  output logic [3:0]                    query_m_o,
  output logic [3:0]                    query_n_o,
  output logic [ADDR_WIDTH-1:0]         query_addr_o
);

  localparam int SWL = $clog2(SLOT_WORDS);

  logic [NUM_SLOTS-1:0]      valid_q, valid_d;
  logic [NUM_SLOTS-1:0]      rsv_q, rsv_d;
  logic [NUM_SLOTS-1:0][3:0] m_q, m_d;
  logic [NUM_SLOTS-1:0][3:0] n_q, n_d;
  logic [NUM_SLOTS-1:0][3:0] rank_q, rank_d;

  logic [IW-1:0] cidx, aidx, qidx;
  logic          commit_hit, abort_hit, q_in;

  assign cidx = commit_slot_i[IW-1:0];
  assign aidx = abort_slot_i[IW-1:0];
  assign qidx = query_slot_i[IW-1:0];
  assign q_in = int'(query_slot_i) < NUM_SLOTS;

  // Only a live reservation can be committed or released.
  assign commit_hit = commit_i && (int'(commit_slot_i) < NUM_SLOTS)
                      && rsv_q[cidx];
  assign abort_hit  = abort_i && (int'(abort_slot_i) < NUM_SLOTS)
                      && rsv_q[aidx];

  always_comb begin
    valid_d = valid_q;
    rsv_d   = rsv_q;
    m_d     = m_q;
    n_d     = n_q;
    rank_d  = rank_q;
    if (commit_hit) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (valid_q[i] && m_q[i] == m_q[cidx] && n_q[i] == n_q[cidx]
            && rank_q[i] != 4'hf)
          rank_d[i] = rank_q[i] + 4'd1;
      end
      valid_d[cidx] = 1'b1;
      rsv_d[cidx]   = 1'b0;
      rank_d[cidx]  = 4'd0;
    end
    if (abort_hit)
      rsv_d[aidx] = 1'b0;
    if (grant_i) begin
      rsv_d[grant_idx_i] = 1'b1;
      m_d[grant_idx_i]   = grant_m_i;
      n_d[grant_idx_i]   = grant_n_i;
      if (grant_evict_i)
        valid_d[grant_idx_i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      rsv_q         <= '0;
      m_q           <= '0;
      n_q           <= '0;
      rank_q        <= '0;
      query_valid_o <= 1'b0;
      query_m_o     <= '0;
      query_n_o     <= '0;
      query_addr_o  <= '0;
    end else begin
      valid_q <= valid_d;
      rsv_q   <= rsv_d;
      m_q     <= m_d;
      n_q     <= n_d;
      rank_q  <= rank_d;
      if (q_in) begin
        query_valid_o <= valid_q[qidx];
        query_m_o     <= m_q[qidx];
        query_n_o     <= n_q[qidx];
        query_addr_o  <= ADDR_WIDTH'(qidx) << SWL;
      end else begin
        query_valid_o <= 1'b0;
        query_m_o     <= '0;
        query_n_o     <= '0;
        query_addr_o  <= '0;
      end
    end
  end

  assign valid_o = valid_q;
  assign rsv_o   = rsv_q;
  assign m_o     = m_q;
  assign n_o     = n_q;
  assign rank_o  = rank_q;
  assign upd_o   = commit_hit | abort_hit;

endmodule

// File: rtl/matrix_slot_allocator.sv
// Matrix BRAM slot allocator: scan/decide FSM over the slot table.
// Define ALLOC_EVICT_EN to reuse the oldest same-dim slot at the limit.
module matrix_slot_allocator
  import matrix_slot_allocator_pkg::*;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int SLOT_WORDS = SLOT_WORDS_DEF,
  parameter int ADDR_WIDTH = `BRAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            config_max_per_dim,
  input  logic                  alloc_req,
  input  logic [3:0]            alloc_m,
  input  logic [3:0]            alloc_n,
  output logic                  alloc_busy,
  output logic                  alloc_done,
  output logic                  alloc_ok,
  output logic [1:0]            alloc_err,
  output logic [3:0]            alloc_slot,
  output logic [ADDR_WIDTH-1:0] alloc_addr,
  output logic                  alloc_evicted,
  input  logic                  commit_req,
  input  logic [3:0]            commit_slot,
  input  logic                  abort_req,
  input  logic [3:0]            abort_slot,
  input  logic [3:0]            query_slot,
  output logic                  query_valid,
  output logic [3:0]            query_m,
  output logic [3:0]            query_n,
  output logic [ADDR_WIDTH-1:0] query_addr
);

  localparam int IW  = $clog2(NUM_SLOTS);
  localparam int SWL = $clog2(SLOT_WORDS);

  alloc_state_e  state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          free_q, free_d;
  logic [IW-1:0] free_idx_q, free_idx_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          vic_q, vic_d;
  logic [IW-1:0] vic_idx_q, vic_idx_d;
  logic [3:0]    vic_rank_q, vic_rank_d;
  logic [3:0]    req_m_q, req_m_d, req_n_q, req_n_d;
  logic          busy_q, busy_d, done_q, done_d, ok_q, ok_d;
  logic [1:0]    err_q, err_d;
  logic [IW-1:0] slot_q, slot_d;
  logic          evict_q, evict_d;

  logic [NUM_SLOTS-1:0]      tbl_valid, tbl_rsv;
  logic [NUM_SLOTS-1:0][3:0] tbl_m, tbl_n, tbl_rank;
  logic                      tbl_upd, grant_en, grant_evict;
  logic [IW-1:0]             grant_idx;
  logic [4:0]                limit;
  logic                      same_dim, is_free, last;

  assign limit    = (config_max_per_dim == 4'd0) ? 5'd1
                                                 : {1'b0, config_max_per_dim};
  assign same_dim = tbl_valid[idx_q] && tbl_m[idx_q] == req_m_q
                    && tbl_n[idx_q] == req_n_q;
  assign is_free  = !tbl_valid[idx_q] && !tbl_rsv[idx_q];
  assign last     = int'(idx_q) == NUM_SLOTS - 1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    free_d      = free_q;
    free_idx_d  = free_idx_q;
    cnt_d       = cnt_q;
    vic_d       = vic_q;
    vic_idx_d   = vic_idx_q;
    vic_rank_d  = vic_rank_q;
    req_m_d     = req_m_q;
    req_n_d     = req_n_q;
    busy_d      = busy_q;
    done_d      = done_q;
    ok_d        = ok_q;
    err_d       = err_q;
    slot_d      = slot_q;
    evict_d     = evict_q;
    grant_en    = 1'b0;
    grant_evict = 1'b0;
    grant_idx   = free_idx_q;
    unique case (state_q)
      S_IDLE: if (alloc_req) begin
        req_m_d = alloc_m;
        req_n_d = alloc_n;
        idx_d   = '0;
        free_d  = 1'b0;
        cnt_d   = '0;
        vic_d   = 1'b0;
        busy_d  = 1'b1;
        ok_d    = 1'b0;
        err_d   = ALLOC_ERR_NONE;
        slot_d  = '0;
        evict_d = 1'b0;
        state_d = S_SCAN;
      end
      // A table change mid-scan invalidates partial results: start over.
      S_SCAN: if (tbl_upd) begin
        idx_d  = '0;
        free_d = 1'b0;
        cnt_d  = '0;
        vic_d  = 1'b0;
      end else begin
        if (is_free && !free_q) begin
          free_d     = 1'b1;
          free_idx_d = idx_q;
        end
        if (same_dim) begin
          cnt_d = cnt_q + 5'd1;
          if (!vic_q || tbl_rank[idx_q] > vic_rank_q) begin
            vic_d      = 1'b1;
            vic_idx_d  = idx_q;
            vic_rank_d = tbl_rank[idx_q];
          end
        end
        if (last) state_d = S_DECIDE;
        else      idx_d   = idx_q + 1'b1;
      end
      S_DECIDE: begin
        state_d = S_RESP;
        done_d  = 1'b1;
        if (cnt_q >= limit) begin
`ifdef ALLOC_EVICT_EN
          grant_en    = 1'b1;
          grant_evict = 1'b1;
          grant_idx   = vic_idx_q;
          ok_d        = 1'b1;
          slot_d      = vic_idx_q;
          evict_d     = 1'b1;
`else
          err_d = ALLOC_ERR_DIM_LIMIT;
`endif
        end else if (free_q) begin
          grant_en  = 1'b1;
          grant_idx = free_idx_q;
          ok_d      = 1'b1;
          slot_d    = free_idx_q;
        end else begin
          err_d = ALLOC_ERR_NO_SPACE;
        end
      end
      S_RESP: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      free_q     <= 1'b0;
      free_idx_q <= '0;
      cnt_q      <= '0;
      vic_q      <= 1'b0;
      vic_idx_q  <= '0;
      vic_rank_q <= '0;
      req_m_q    <= '0;
      req_n_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= '0;
      slot_q     <= '0;
      evict_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      free_q     <= free_d;
      free_idx_q <= free_idx_d;
      cnt_q      <= cnt_d;
      vic_q      <= vic_d;
      vic_idx_q  <= vic_idx_d;
      vic_rank_q <= vic_rank_d;
      req_m_q    <= req_m_d;
      req_n_q    <= req_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      slot_q     <= slot_d;
      evict_q    <= evict_d;
    end
  end

  matrix_slot_allocator_table #(
    .NUM_SLOTS  (NUM_SLOTS),
    .SLOT_WORDS (SLOT_WORDS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_table (
    .clk           (clk),
    .rst           (rst),
    .commit_i      (commit_req),
    .commit_slot_i (commit_slot),
    .abort_i       (abort_req),
    .abort_slot_i  (abort_slot),
    .grant_i       (grant_en),
    .grant_evict_i (grant_evict),
    .grant_idx_i   (grant_idx),
    .grant_m_i     (req_m_q),
    .grant_n_i     (req_n_q),
    .query_slot_i  (query_slot),
    .valid_o       (tbl_valid),
    .rsv_o         (tbl_rsv),
    .m_o           (tbl_m),
    .n_o           (tbl_n),
    .rank_o        (tbl_rank),
    .upd_o         (tbl_upd),
    .query_valid_o (query_valid),
    .query_m_o     (query_m),
    .query_n_o     (query_n),
    .query_addr_o  (query_addr)
  );

  assign alloc_busy    = busy_q;
  assign alloc_done    = done_q;
  assign alloc_ok      = ok_q;
  assign alloc_err     = err_q;
  assign alloc_slot    = 4'(slot_q);
  assign alloc_addr    = ADDR_WIDTH'(slot_q) << SWL;
  assign alloc_evicted = evict_q;

endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Bench for matrix_slot_allocator: directed scenarios plus random
// alloc/commit/abort traffic against a commit-order reference model.
module tb_matrix_slot_allocator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cfg = 4'd15;
  logic       alloc_req = 1'b0;
  logic [3:0] alloc_m = 4'd1, alloc_n = 4'd1;
  logic       alloc_busy, alloc_done, alloc_ok, alloc_evicted;
  logic [1:0] alloc_err;
  logic [3:0] alloc_slot;
  logic [7:0] alloc_addr;
  logic       commit_req = 1'b0, abort_req = 1'b0;
  logic [3:0] commit_slot = 4'd0, abort_slot = 4'd0, query_slot = 4'd0;
  logic       query_valid;
  logic [3:0] query_m, query_n;
  logic [7:0] query_addr;

  always #5 clk = ~clk;

  matrix_slot_allocator dut (
    .clk (clk), .rst (rst), .config_max_per_dim (cfg),
    .alloc_req (alloc_req), .alloc_m (alloc_m), .alloc_n (alloc_n),
    .alloc_busy (alloc_busy), .alloc_done (alloc_done),
    .alloc_ok (alloc_ok), .alloc_err (alloc_err),
    .alloc_slot (alloc_slot), .alloc_addr (alloc_addr),
    .alloc_evicted (alloc_evicted),
    .commit_req (commit_req), .commit_slot (commit_slot),
    .abort_req (abort_req), .abort_slot (abort_slot),
    .query_slot (query_slot), .query_valid (query_valid),
    .query_m (query_m), .query_n (query_n), .query_addr (query_addr)
  );

`ifdef ALLOC_EVICT_EN
  localparam bit EVICT = 1'b1;
`else
  localparam bit EVICT = 1'b0;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  // Reference: per slot valid/reserved/dims and the commit sequence number.
  int mv[8], mr[8], mm[8], mn[8], mts[8];
  int seq;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 0; mr[i] = 0; mm[i] = 0; mn[i] = 0; mts[i] = 0;
    end
    seq = 0;
  endfunction

  function automatic bit m_commit(input int s);
    if (s < 8 && mr[s] != 0) begin
      seq++;
      mv[s] = 1; mr[s] = 0; mts[s] = seq;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_abort(input int s);
    if (s < 8 && mr[s] != 0) begin
      mr[s] = 0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Oldest committed same-dim matrix is the eviction victim.
  function automatic void m_alloc(input int m, input int n, input int lim_cfg,
                                  output int ok, output int err,
                                  output int slot, output int ev);
    int cnt, vic, fr, lim;
    cnt = 0; vic = -1; fr = -1;
    lim = (lim_cfg == 0) ? 1 : lim_cfg;
    for (int i = 0; i < 8; i++) begin
      if (mv[i] != 0 && mm[i] == m && mn[i] == n) begin
        cnt++;
        if (vic < 0 || mts[i] < mts[vic]) vic = i;
      end
      if (mv[i] == 0 && mr[i] == 0 && fr < 0) fr = i;
    end
    ok = 0; err = 0; slot = 0; ev = 0;
    if (cnt >= lim) begin
      if (EVICT) begin ok = 1; slot = vic; ev = 1; end
      else err = 2;
    end else if (fr >= 0) begin
      ok = 1; slot = fr;
    end else err = 1;
    if (ok != 0) begin
      mr[slot] = 1; mm[slot] = m; mn[slot] = n;
      if (ev != 0) mv[slot] = 0;
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1; alloc_req = 1'b0; commit_req = 1'b0; abort_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
  endtask

  task automatic commit(input int s);
    bit e;
    commit_slot = 4'(s); commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    e = m_commit(s);
  endtask

  task automatic abort(input int s);
    bit e;
    abort_slot = 4'(s); abort_req = 1'b1;
    @(negedge clk);
    abort_req = 1'b0;
    e = m_abort(s);
  endtask

  task automatic query(input int s, input string tag);
    query_slot = 4'(s);
    @(negedge clk);
    chk({tag, ".qv"}, 32'(query_valid), mv[s]);
    if (mv[s] != 0) begin
      chk({tag, ".qm"}, 32'(query_m), mm[s]);
      chk({tag, ".qn"}, 32'(query_n), mn[s]);
    end
    chk({tag, ".qaddr"}, 32'(query_addr), s * 32);
  endtask

  // Optional commit/abort injected mk cycles into the request.
  task automatic do_alloc(input int m, input int n, input int mk,
                          input bit mcommit, input int ms,
                          input string tag, output int gok, output int gslot);
    int lat, ok, err, slot, ev;
    bit eff;
    eff = 1'b0;
    alloc_m = 4'(m); alloc_n = 4'(n); alloc_req = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      alloc_req = 1'b0; commit_req = 1'b0; abort_req = 1'b0;
      if (alloc_done === 1'b1 || lat > 60) break;
      if (lat == mk) begin
        if (mcommit) begin
          commit_slot = 4'(ms); commit_req = 1'b1; eff = m_commit(ms);
        end else begin
          abort_slot = 4'(ms); abort_req = 1'b1; eff = m_abort(ms);
        end
      end
    end
    chk({tag, ".lat"}, lat, eff ? 10 + mk : 10);
    m_alloc(m, n, int'(cfg), ok, err, slot, ev);
    chk({tag, ".ok"}, 32'(alloc_ok), ok);
    chk({tag, ".err"}, 32'(alloc_err), err);
    chk({tag, ".ev"}, 32'(alloc_evicted), ev);
    if (ok != 0) begin
      chk({tag, ".slot"}, 32'(alloc_slot), slot);
      chk({tag, ".addr"}, 32'(alloc_addr), slot * 32);
    end
    @(negedge clk);
    chk({tag, ".busy"}, 32'(alloc_busy), 0);
    gok = ok; gslot = slot;
  endtask

  initial begin
    int ok, sl, r;
    m_reset();
    @(negedge clk);
    chk("rst.busy", 32'(alloc_busy), 0);
    chk("rst.done", 32'(alloc_done), 0);
    chk("rst.ok", 32'(alloc_ok), 0);
    chk("rst.err", 32'(alloc_err), 0);
    chk("rst.slot", 32'(alloc_slot), 0);
    chk("rst.qv", 32'(query_valid), 0);
    chk("rst.qaddr", 32'(query_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    cfg = 4'd15;
    do_alloc(2, 3, 0, 1'b0, 0, "t1", ok, sl);
    chk("t1.slot0", 32'(alloc_slot), 0);
    commit(0);
    query(0, "t1.q0");
    chk("t1.qm2", 32'(query_m), 2);
    chk("t1.qn3", 32'(query_n), 3);
    query(5, "t1.q5");

    do_reset();
    cfg = 4'd2;
    do_alloc(2, 2, 0, 1'b0, 0, "t2a", ok, sl);
    commit(sl);
    do_alloc(2, 2, 0, 1'b0, 0, "t2b", ok, sl);
    commit(sl);
    do_alloc(2, 2, 0, 1'b0, 0, "t2c", ok, sl);
`ifdef ALLOC_EVICT_EN
    chk("t2.evslot", 32'(alloc_slot), 0);
    chk("t2.evicted", 32'(alloc_evicted), 1);
    commit(0);
    query(0, "t2.q0");
`else
    chk("t2.refused", 32'(alloc_ok), 0);
    chk("t2.err2", 32'(alloc_err), 2);
    query(0, "t2.q0");
`endif
    query(1, "t2.q1");

    do_reset();
    cfg = 4'd15;
    for (int k = 0; k < 8; k++) begin
      do_alloc(1 + k % 5, 1 + k / 5, 0, 1'b0, 0, "t3", ok, sl);
      commit(sl);
    end
    do_alloc(1, 1, 0, 1'b0, 0, "t3.ninth", ok, sl);
    chk("t3.err1", 32'(alloc_err), 1);

    do_reset();
    do_alloc(1, 1, 0, 1'b0, 0, "t4a", ok, sl);
    abort(0);
    do_alloc(1, 1, 0, 1'b0, 0, "t4b", ok, sl);
    chk("t4.reuse0", 32'(alloc_slot), 0);
    commit(3);
    commit(12);
    query(3, "t4.q3");
    chk("t4.q3inv", 32'(query_valid), 0);

    do_reset();
    do_alloc(1, 1, 0, 1'b0, 0, "t5a", ok, sl);
    do_alloc(1, 2, 0, 1'b0, 0, "t5b", ok, sl);
    do_alloc(2, 2, 3, 1'b1, 0, "t5c", ok, sl);
    chk("t5.skip", 32'(alloc_slot), 2);
    do_alloc(3, 3, 5, 1'b0, 1, "t5d", ok, sl);
    chk("t5.freed", 32'(alloc_slot), 1);

    do_reset();
    do_alloc(4, 4, 0, 1'b0, 0, "t6a", ok, sl);
    commit(0);
    alloc_m = 4'd4; alloc_n = 4'd4; alloc_req = 1'b1;
    @(negedge clk);
    alloc_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6.busy", 32'(alloc_busy), 0);
    chk("t6.done", 32'(alloc_done), 0);
    chk("t6.qv", 32'(query_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    query(0, "t6.q0");
    do_alloc(4, 4, 0, 1'b0, 0, "t6b", ok, sl);

    do_reset();
    for (int it = 0; it < 80; it++) begin
      int mk;
      cfg = 4'($urandom_range(0, 3));
      mk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      do_alloc(int'($urandom_range(1, 2)), int'($urandom_range(1, 2)), mk,
               1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               "rnd", ok, sl);
      if (ok != 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 6)      commit(sl);
        else if (r < 8) abort(sl);
      end
      if ($urandom_range(0, 3) == 0) abort(int'($urandom_range(0, 7)));
      query(int'($urandom_range(0, 7)), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
